// File: rtl/divider_8.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH clocks per
// operation, with an immediate all-ones/dividend result for a zero divisor.
module divider_8 #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [1:0]       dbg_state
);

  // Handshake: Start is a level request sampled only in IDLE; the accepting
  // edge latches Dividend/Divisor. Done stays high until Start is seen low,
  // so a held Start yields exactly one operation. Results change only on
  // entry to DONE and otherwise hold.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH+1:0] trial;
  logic             step_ok;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             last_step;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // One restoring step; the extra top bit of trial is the borrow/sign.
  always_comb begin
    r_sh      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    q_sh      = {q_q[WIDTH-2:0], 1'b0};
    trial     = {1'b0, r_sh} - {2'b00, d_q};
    step_ok   = ~trial[WIDTH+1];
    r_step    = step_ok ? trial[WIDTH:0] : r_sh;
    q_step    = {q_sh[WIDTH-1:1], step_ok};
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          q_d   = Dividend;
          d_d   = Divisor;
          r_d   = '0;
          cnt_d = '0;
          if (Divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = Dividend;
            div_zero_d  = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          state_d     = S_DONE;
          quotient_d  = q_step;
          remainder_d = r_step[WIDTH-1:0];
          div_zero_d  = 1'b0;
        end
      end
      S_DONE: begin
        if (!Start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    Busy      = (state_q == S_CALC);
    Done      = (state_q == S_DONE);
    dbg_state = state_q;
    Quotient  = quotient_q;
    Remainder = remainder_q;
    DivZero   = div_zero_q;
  end

endmodule

// File: doc/divider_8.md
DIVIDER_8 -- requirements
Module: divider_8

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; supported values 2..16.
REQ-002 Port: Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, independent of Clk.
REQ-004 Port: Start  input  1  level request; sampled only in IDLE; already synchronized by the caller.
REQ-005 Port: Dividend  input  WIDTH  unsigned numerator; sampled on the edge that accepts Start.
REQ-006 Port: Divisor  input  WIDTH  unsigned denominator; sampled on the same edge as Dividend.
REQ-007 Port: Quotient  output  WIDTH  registered unsigned result.
REQ-008 Port: Remainder  output  WIDTH  registered unsigned result.
REQ-009 Port: Busy  output  1  high while in CALC.
REQ-010 Port: Done  output  1  high while in DONE.
REQ-011 Port: DivZero  output  1  registered; high when the last completed operation had Divisor = 0.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-013 IDLE: Start=1 at an edge -> capture Dividend into working quotient Q, Divisor into D, clear partial remainder R (WIDTH+1 bits) and iteration counter, go to CALC; if captured Divisor=0 go directly to DONE instead.
REQ-014 CALC: each edge SHALL perform one restoring step: {R,Q} shifted left 1 bit; trial = R - {0,D} at WIDTH+1 bits; trial non-negative -> R=trial, Q[0]=1; else R unchanged, Q[0]=0; counter increments.
REQ-015 CALC SHALL last exactly WIDTH edges; on the WIDTH-th step edge, Quotient<=Q, Remainder<=R[WIDTH-1:0], DivZero<=0, state -> DONE.
REQ-016 Latency: Done SHALL first be high WIDTH edges after the Start-accepting edge (8 edges for WIDTH=8); for Divisor=0, 1 edge.
REQ-017 Divisor=0: Quotient <= all ones, Remainder <= captured Dividend, DivZero <= 1, no CALC cycles.
REQ-018 DONE: hold state while Start=1; Start=0 at an edge -> IDLE (one operation per Start assertion, no auto-retrigger).
REQ-019 Start, Dividend, Divisor changes during CALC or DONE SHALL be ignored.
REQ-020 Quotient, Remainder, DivZero SHALL change only on entry to DONE and hold through IDLE and the next CALC.
REQ-021 Busy and Done SHALL be decoded from state only (Moore), never both high.
REQ-022 Results SHALL satisfy Dividend = Quotient*Divisor + Remainder, Remainder < Divisor, for all nonzero Divisor.

Reset
REQ-023 Reset=0 SHALL asynchronously set state IDLE and clear Quotient, Remainder, DivZero, Busy, Done, Q, R, D, and counter to 0.
REQ-024 Reset asserted mid-CALC SHALL abort the operation with no result update; after release, the block SHALL wait in IDLE for Start=1.
REQ-025 Start already high on the first edge after Reset release SHALL be accepted as a new request.

Verification
REQ-026 Dividend=100, Divisor=7, Start pulse held -> Busy 8 cycles, then Done=1, Quotient=14, Remainder=2, DivZero=0.
REQ-027 255/1 -> Quotient=255, Remainder=0; 255/255 -> 1, 0; 5/200 -> 0, 5.
REQ-028 37/0 -> Done one edge after Start, Quotient=0xFF, Remainder=37, DivZero=1, Busy never high.
REQ-029 Reset=0 at CALC step 4 of 100/7 -> all outputs 0, state IDLE; rerun 9/3 -> Quotient=3, Remainder=0.
REQ-030 Start held high 20 cycles after 100/7 -> exactly one operation, Done stays 1; Operands changed during CALC leave result 14/2; Start low -> IDLE, outputs hold.
REQ-031 Random sweep, 10^4 pairs including all-zero/all-one corners -> REQ-022 holds; latency matches REQ-016.
